// File: rtl/rv_lzc_norm_if.sv
// Handshake bundle for rv_lzc_norm: input transaction channel and result channel.
// The master side drives transactions and result acceptance; the slave side is the counter.
interface rv_lzc_norm_if #(
    parameter int N     = 32,
    parameter int LANES = 4,
    parameter int TAGW  = 4
);
    localparam int CNTW = $clog2(N) + 1;

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [LANES*N-1:0]    in_data_i;
    logic                  in_mode_i;
    logic [TAGW-1:0]       in_tag_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [LANES*CNTW-1:0] out_cnt_o;
    logic [LANES-1:0]      out_zero_o;
    logic [LANES*N-1:0]    out_norm_o;
    logic [TAGW-1:0]       out_tag_o;

    modport master (
        output in_valid_i, in_data_i, in_mode_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_cnt_o, out_zero_o, out_norm_o, out_tag_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_mode_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_cnt_o, out_zero_o, out_norm_o, out_tag_o
    );
endinterface

// File: rtl/rv_lzc_norm.sv
// Two-stage elastic leading/trailing zero counter with per-lane normalisation.
// S1 registers the word and its count; S2 registers the shifted word, zero flag and tag.
module rv_lzc_norm #(
    parameter int N     = 32,
    parameter int LANES = 4,
    parameter int TAGW  = 4
) (
    input logic          clk,
    input logic          reset_n,
    rv_lzc_norm_if.slave bus
);
    localparam int CNTW = $clog2(N) + 1;

    logic                  r_s1_valid;
    logic [LANES*N-1:0]    r_s1_data;
    logic                  r_s1_mode;
    logic [TAGW-1:0]       r_s1_tag;
    logic [LANES*CNTW-1:0] r_s1_cnt;

    logic                  r_s2_valid;
    logic [LANES*CNTW-1:0] r_s2_cnt;
    logic [LANES-1:0]      r_s2_zero;
    logic [LANES*N-1:0]    r_s2_norm;
    logic [TAGW-1:0]       r_s2_tag;

    logic                  w_s2_ready;
    logic                  w_s1_ready;
    logic                  w_in_fire;
    logic                  w_s1_move;
    logic [LANES*CNTW-1:0] w_cnt;
    logic [LANES-1:0]      w_zero;
    logic [LANES*N-1:0]    w_norm;

    function automatic logic [CNTW-1:0] f_lzc(input logic [N-1:0] word);
        logic [CNTW-1:0] cnt;
        logic            hit;
        cnt = CNTW'(N);
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!hit && word[i]) begin
                cnt = CNTW'(N - 1 - i);
                hit = 1'b1;
            end
        end
        return cnt;
    endfunction

    function automatic logic [CNTW-1:0] f_tzc(input logic [N-1:0] word);
        logic [CNTW-1:0] cnt;
        logic            hit;
        cnt = CNTW'(N);
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!hit && word[i]) begin
                cnt = CNTW'(i);
                hit = 1'b1;
            end
        end
        return cnt;
    endfunction

    assign w_s2_ready     = !r_s2_valid || bus.out_ready_i;
    assign w_s1_ready     = !r_s1_valid || w_s2_ready;
    assign w_in_fire      = bus.in_valid_i && w_s1_ready;
    assign w_s1_move      = r_s1_valid && w_s2_ready;
    assign bus.in_ready_o = w_s1_ready;

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            w_cnt[k*CNTW +: CNTW] = bus.in_mode_i ? f_lzc(bus.in_data_i[k*N +: N])
                                                  : f_tzc(bus.in_data_i[k*N +: N]);
        end
    end

    // A count of N only arises from an all-zero word; the shift then clears the word anyway,
    // but the explicit zero keeps the result independent of shift-overflow semantics.
    always_comb begin
        w_zero = '0;
        w_norm = '0;
        for (int k = 0; k < LANES; k++) begin
            w_zero[k] = (r_s1_cnt[k*CNTW +: CNTW] == CNTW'(N));
            if (!w_zero[k]) begin
                w_norm[k*N +: N] = r_s1_mode ? (r_s1_data[k*N +: N] << r_s1_cnt[k*CNTW +: CNTW])
                                             : (r_s1_data[k*N +: N] >> r_s1_cnt[k*CNTW +: CNTW]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_cnt   <= '0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= bus.in_valid_i;
            end
            if (w_in_fire) begin
                r_s1_data <= bus.in_data_i;
                r_s1_mode <= bus.in_mode_i;
                r_s1_tag  <= bus.in_tag_i;
                r_s1_cnt  <= w_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_cnt   <= '0;
            r_s2_zero  <= '0;
            r_s2_norm  <= '0;
            r_s2_tag   <= '0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_move) begin
                r_s2_cnt  <= r_s1_cnt;
                r_s2_zero <= w_zero;
                r_s2_norm <= w_norm;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign bus.out_valid_o = r_s2_valid;
    assign bus.out_cnt_o   = r_s2_cnt;
    assign bus.out_zero_o  = r_s2_zero;
    assign bus.out_norm_o  = r_s2_norm;
    assign bus.out_tag_o   = r_s2_tag;

endmodule

// File: tb/tb_rv_lzc_norm.sv
// Self-checking bench for rv_lzc_norm: directed scenarios plus a randomized stream
// compared against a shift-until-set reference model.
module tb_rv_lzc_norm;
    localparam int N     = 32;
    localparam int LANES = 4;
    localparam int TAGW  = 4;
    localparam int CNTW  = $clog2(N) + 1;
    localparam int NRAND = 10000;

    typedef struct {
        logic [LANES*CNTW-1:0] cnt;
        logic [LANES-1:0]      zero;
        logic [LANES*N-1:0]    norm;
        logic [TAGW-1:0]       tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv_lzc_norm_if #(.N(N), .LANES(LANES), .TAGW(TAGW)) bus ();

    rv_lzc_norm #(.N(N), .LANES(LANES), .TAGW(TAGW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference: shift the word toward the counted edge until a set bit reaches it.
    function automatic exp_t model(input logic [LANES*N-1:0] d, input logic m, input logic [TAGW-1:0] t);
        exp_t e;
        e.tag = t;
        e.cnt = '0;
        e.zero = '0;
        e.norm = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [N-1:0] w;
            int c;
            w = d[k*N +: N];
            c = 0;
            while (c < N && (m ? !w[N-1] : !w[0])) begin
                w = m ? (w << 1) : (w >> 1);
                c++;
            end
            e.cnt[k*CNTW +: CNTW] = CNTW'(c);
            e.zero[k]             = (c == N);
            e.norm[k*N +: N]      = w;
        end
        return e;
    endfunction

    function automatic logic [N-1:0] gen_word();
        logic [N-1:0] w;
        case ($urandom_range(0, 4))
            0:       w = '0;
            1:       w = N'(1) << $urandom_range(0, N - 1);
            2:       w = N'($urandom);
            3:       w = N'($urandom) >> $urandom_range(0, N - 1);
            default: w = N'($urandom) << $urandom_range(0, N - 1);
        endcase
        return w;
    endfunction

    function automatic logic [LANES*N-1:0] gen_data();
        logic [LANES*N-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*N +: N] = gen_word();
        return d;
    endfunction

    task automatic drive(input logic v, input logic [LANES*N-1:0] d, input logic m,
                         input logic [TAGW-1:0] t, input logic ordy);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.in_mode_i   = m;
        bus.in_tag_i    = t;
        bus.out_ready_i = ordy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); end
        checks++; if (bus.out_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", bus.out_cnt_o); end
        checks++; if (bus.out_zero_o !== '0) begin errors++; $display("FAIL reset_zero got %h want 0", bus.out_zero_o); end
        checks++; if (bus.out_norm_o !== '0) begin errors++; $display("FAIL reset_norm got %h want 0", bus.out_norm_o); end
        checks++; if (bus.out_tag_o !== '0) begin errors++; $display("FAIL reset_tag got %h want 0", bus.out_tag_o); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count_norm();
        for (int mi = 0; mi < 2; mi++) begin
            logic               m;
            logic [LANES*N-1:0] d;
            logic [TAGW-1:0]    t;
            exp_t               e;
            m = (mi == 0);
            d = gen_data();
            d[N-1:0] = 32'h0001_0000;
            t = m ? 4'hA : 4'h5;
            e = model(d, m, t);
            drive(1'b1, d, m, t, 1'b1);
            #1;
            checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL cn_in_ready got %b want 1", bus.in_ready_o); end
            @(negedge clk);
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            #1;
            checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL cn_early_valid got %b want 0", bus.out_valid_o); end
            @(negedge clk);
            #1;
            checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL cn_latency_valid got %b want 1", bus.out_valid_o); end
            checks++; if (bus.out_cnt_o[CNTW-1:0] !== (m ? CNTW'(15) : CNTW'(16))) begin errors++; $display("FAIL cn_lane0_cnt mode %0d got %0d want %0d", m, bus.out_cnt_o[CNTW-1:0], m ? 15 : 16); end
            checks++; if (bus.out_norm_o[N-1:0] !== (m ? 32'h8000_0000 : 32'h0000_0001)) begin errors++; $display("FAIL cn_lane0_norm mode %0d got %h", m, bus.out_norm_o[N-1:0]); end
            checks++; if (bus.out_zero_o[0] !== 1'b0) begin errors++; $display("FAIL cn_lane0_zero got %b want 0", bus.out_zero_o[0]); end
            checks++; if (bus.out_cnt_o !== e.cnt || bus.out_norm_o !== e.norm || bus.out_zero_o !== e.zero || bus.out_tag_o !== e.tag) begin
                errors++; $display("FAIL cn_all_lanes got cnt %h zero %h tag %h want cnt %h zero %h tag %h", bus.out_cnt_o, bus.out_zero_o, bus.out_tag_o, e.cnt, e.zero, e.tag);
            end
            @(negedge clk);
            checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL cn_drained got %b want 0", bus.out_valid_o); end
        end
    endtask

    task automatic test_edges();
        logic [N-1:0] w[2][LANES];
        int           c[2][LANES];
        logic [N-1:0] nv[2][LANES];
        w[0] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        c[0] = '{32, 0, 0, 31};
        nv[0] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        w[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0002};
        c[1] = '{32, 0, 31, 1};
        nv[1] = '{32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        for (int s = 0; s < 2; s++) begin
            logic [LANES*N-1:0] d;
            logic               m;
            exp_t               e;
            m = (s == 0);
            for (int k = 0; k < LANES; k++) d[k*N +: N] = w[s][k];
            e = model(d, m, TAGW'(s + 3));
            drive(1'b1, d, m, TAGW'(s + 3), 1'b1);
            @(negedge clk);
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            @(negedge clk);
            checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL edge_valid case %0d got %b want 1", s, bus.out_valid_o); end
            for (int k = 0; k < LANES; k++) begin
                checks++;
                if (bus.out_cnt_o[k*CNTW +: CNTW] !== CNTW'(c[s][k]) || bus.out_norm_o[k*N +: N] !== nv[s][k] ||
                    bus.out_zero_o[k] !== (c[s][k] == N)) begin
                    errors++; $display("FAIL edge_lane case %0d lane %0d got cnt %0d norm %h zero %b want cnt %0d norm %h", s, k,
                        bus.out_cnt_o[k*CNTW +: CNTW], bus.out_norm_o[k*N +: N], bus.out_zero_o[k], c[s][k], nv[s][k]);
                end
            end
            checks++; if (bus.out_cnt_o !== e.cnt || bus.out_norm_o !== e.norm || bus.out_tag_o !== e.tag) begin errors++; $display("FAIL edge_model case %0d got cnt %h want %h", s, bus.out_cnt_o, e.cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        q.delete();
        for (int i = 0; i < 8; i++) begin
            logic [LANES*N-1:0] d;
            logic               m;
            d = gen_data();
            m = 1'($urandom);
            drive(i < 5, d, m, TAGW'(i + 1), 1'b1);
            #1;
            if (i < 5) begin
                checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", i, bus.in_ready_o); end
            end
            checks++; if (bus.out_valid_o !== (i >= 2 && i <= 6)) begin errors++; $display("FAIL b2b_valid cycle %0d got %b want %b", i, bus.out_valid_o, (i >= 2 && i <= 6)); end
            if (bus.out_valid_o === 1'b1) begin
                exp_t e;
                checks++; if (bus.out_tag_o !== TAGW'(i - 1)) begin errors++; $display("FAIL b2b_tag cycle %0d got %0d want %0d", i, bus.out_tag_o, i - 1); end
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra cycle %0d got result want none", i);
                end else begin
                    e = q.pop_front();
                    checks++; if (bus.out_cnt_o !== e.cnt || bus.out_norm_o !== e.norm || bus.out_zero_o !== e.zero) begin errors++; $display("FAIL b2b_data cycle %0d got cnt %h want %h", i, bus.out_cnt_o, e.cnt); end
                end
            end
            if (i < 5 && bus.in_ready_o === 1'b1) q.push_back(model(d, m, TAGW'(i + 1)));
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int   accepted;
        int   drained;
        exp_t snap;
        q.delete();
        accepted = 0;
        snap = '{default: '0};
        for (int i = 0; i < 6; i++) begin
            logic [LANES*N-1:0] d;
            logic               m;
            d = gen_data();
            m = 1'($urandom);
            drive(1'b1, d, m, TAGW'(8 + i), 1'b0);
            #1;
            checks++; if (bus.in_ready_o !== (i < 2)) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want %b", i, bus.in_ready_o, (i < 2)); end
            if (bus.in_ready_o === 1'b1) begin
                accepted++;
                q.push_back(model(d, m, TAGW'(8 + i)));
            end
            if (i == 2) begin
                snap.cnt = bus.out_cnt_o; snap.zero = bus.out_zero_o; snap.norm = bus.out_norm_o; snap.tag = bus.out_tag_o;
            end else if (i > 2) begin
                checks++; if (bus.out_valid_o !== 1'b1 || bus.out_cnt_o !== snap.cnt || bus.out_zero_o !== snap.zero ||
                              bus.out_norm_o !== snap.norm || bus.out_tag_o !== snap.tag) begin
                    errors++; $display("FAIL bp_stable cycle %0d got valid %b tag %h cnt %h want valid 1 tag %h cnt %h", i, bus.out_valid_o, bus.out_tag_o, bus.out_cnt_o, snap.tag, snap.cnt);
                end
            end
            @(negedge clk);
        end
        checks++; if (accepted !== 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", accepted); end
        drained = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            #1;
            if (i < 3) begin
                checks++; if (bus.out_valid_o !== (i < 2)) begin errors++; $display("FAIL bp_drain_valid cycle %0d got %b want %b", i, bus.out_valid_o, (i < 2)); end
            end
            if (bus.out_valid_o === 1'b1) begin
                drained++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_duplicate cycle %0d got extra result want none", i);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks++; if (bus.out_cnt_o !== e.cnt || bus.out_norm_o !== e.norm || bus.out_zero_o !== e.zero || bus.out_tag_o !== e.tag) begin
                        errors++; $display("FAIL bp_drain_data cycle %0d got tag %h cnt %h want tag %h cnt %h", i, bus.out_tag_o, bus.out_cnt_o, e.tag, e.cnt);
                    end
                end
            end
            @(negedge clk);
        end
        checks++; if (drained !== 2) begin errors++; $display("FAIL bp_drained got %0d want 2", drained); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, gen_data(), 1'($urandom), TAGW'(12 + i), 1'b0);
            @(negedge clk);
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        #2;
        checks++; if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_preload got valid %b ready %b want 1 0", bus.out_valid_o, bus.in_ready_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", bus.out_valid_o); end
        checks++; if (bus.out_cnt_o !== '0 || bus.out_zero_o !== '0 || bus.out_norm_o !== '0 || bus.out_tag_o !== '0) begin
            errors++; $display("FAIL rst_async_data got cnt %h tag %h want 0", bus.out_cnt_o, bus.out_tag_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            #1;
            if (i == 0) begin
                checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready_o); end
            end
            if (bus.out_valid_o === 1'b1) stale++;
            @(negedge clk);
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rst_stale got %0d results want 0", stale); end
    endtask

    task automatic test_random();
        int sent;
        int got;
        int cyc;
        q.delete();
        sent = 0;
        got = 0;
        cyc = 0;
        while ((sent < NRAND || q.size() != 0) && cyc < 60000) begin
            logic [LANES*N-1:0] d;
            logic               m;
            logic [TAGW-1:0]    t;
            logic               v;
            logic               r;
            d = gen_data();
            m = 1'($urandom);
            t = TAGW'($urandom);
            v = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            drive(v, d, m, t, r);
            #1;
            if (bus.out_valid_o === 1'b1 && r) begin
                got++;
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_unexpected cycle %0d got tag %h want none", cyc, bus.out_tag_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks++; if (bus.out_cnt_o !== e.cnt) begin errors++; $display("FAIL rnd_cnt result %0d got %h want %h", got, bus.out_cnt_o, e.cnt); end
                    checks++; if (bus.out_zero_o !== e.zero) begin errors++; $display("FAIL rnd_zero result %0d got %h want %h", got, bus.out_zero_o, e.zero); end
                    checks++; if (bus.out_norm_o !== e.norm) begin errors++; $display("FAIL rnd_norm result %0d got %h want %h", got, bus.out_norm_o, e.norm); end
                    checks++; if (bus.out_tag_o !== e.tag) begin errors++; $display("FAIL rnd_tag result %0d got %h want %h", got, bus.out_tag_o, e.tag); end
                end
            end
            if (v && bus.in_ready_o === 1'b1) begin
                q.push_back(model(d, m, t));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (sent !== NRAND || q.size() != 0) begin errors++; $display("FAIL rnd_timeout got sent %0d pending %0d want sent %0d pending 0", sent, q.size(), NRAND); end
        checks++; if (got !== NRAND) begin errors++; $display("FAIL rnd_count got %0d want %0d", got, NRAND); end
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        test_reset();
        test_count_norm();
        test_edges();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
